// File: rtl/frame_buffer_sequencer_if.sv
// ---------------------------------------------------------------------------
// frame_buffer_sequencer_if
// Burst command handshake between a requester (frame_buffer_sequencer) and
// the DDR2 arbiter (mem_arbiter).
//   wr_req / wr_ack / wr_addr : write burst request, ack and 24-bit address
//   rd_req / rd_ack / rd_addr : read burst request, ack and 24-bit address
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface frame_buffer_sequencer_if;
   logic        wr_req;
   logic        wr_ack;
   logic [23:0] wr_addr;
   logic        rd_req;
   logic        rd_ack;
   logic [23:0] rd_addr;

   modport master (
      output wr_req,
      output wr_addr,
      output rd_req,
      output rd_addr,
      input  wr_ack,
      input  rd_ack
   );

   modport slave (
      input  wr_req,
      input  wr_addr,
      input  rd_req,
      input  rd_addr,
      output wr_ack,
      output rd_ack
   );
endinterface

// File: rtl/frame_buffer_sequencer.sv
// ---------------------------------------------------------------------------
// frame_buffer_sequencer
// Triple-buffered camera frame store sequencer.  Generates DDR2 write bursts
// for incoming frames and read bursts for host frame readout.  Writes are
// paced by write-FIFO fill; reads by read-FIFO space minus in-flight words.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   i_calib_done          memory calibration complete
//   i_frame_start         pulse: sensor frame begins
//   i_wfifo_count         words readable in write FIFO
//   i_rfifo_space         free words in read FIFO
//   i_rdata_valid         one read word delivered to read FIFO
//   i_rd_frame_req        pulse: host requests a frame
//   o_rd_frame_busy       frame readout in progress
//   o_rd_frame_done       pulse: readout finished
//   o_rd_frame_none       pulse: request rejected, no complete frame
//   o_frame_written       pulse: frame completed to memory
//   arb                   arbiter handshake (master modport)
//   o_frames_written_cnt  statistics (FBSEQ_STATS_EN)
//   o_frames_dropped_cnt  statistics (FBSEQ_STATS_EN)
//
// Build option: define FBSEQ_STATS_EN to build the saturating frame counters;
// otherwise both statistics ports are tied to zero.
// ---------------------------------------------------------------------------
module frame_buffer_sequencer #(
   parameter int unsigned BURST_WORDS  = 8,
   parameter logic [23:0] FRAME_BURSTS = 24'd9600,
   parameter logic [23:0] BUF_STRIDE   = 24'h080000,
   parameter logic [23:0] BUF_BASE     = 24'h000000
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            i_calib_done,
   input  logic                            i_frame_start,
   input  logic [9:0]                      i_wfifo_count,
   input  logic [9:0]                      i_rfifo_space,
   input  logic                            i_rdata_valid,
   input  logic                            i_rd_frame_req,
   output logic                            o_rd_frame_busy,
   output logic                            o_rd_frame_done,
   output logic                            o_rd_frame_none,
   output logic                            o_frame_written,
   frame_buffer_sequencer_if.master        arb,
   output logic [15:0]                     o_frames_written_cnt,
   output logic [15:0]                     o_frames_dropped_cnt
);

   localparam logic [23:0] BW24 = 24'(BURST_WORDS);
   localparam logic [11:0] BW12 = 12'(BURST_WORDS);
   localparam logic [10:0] BW11 = 11'(BURST_WORDS);

   localparam logic [2:0] W_CALIB   = 3'd0;
   localparam logic [2:0] W_IDLE    = 3'd1;
   localparam logic [2:0] W_CHECK   = 3'd2;
   localparam logic [2:0] W_REQ     = 3'd3;
   localparam logic [2:0] W_RELEASE = 3'd4;

   localparam logic [1:0] R_IDLE    = 2'd0;
   localparam logic [1:0] R_CHECK   = 2'd1;
   localparam logic [1:0] R_REQ     = 2'd2;
   localparam logic [1:0] R_RELEASE = 2'd3;

   // Write side state
   logic [2:0]  r_wr_state;
   logic [1:0]  r_wr_buf;
   logic [23:0] r_wr_idx;
   logic        r_wr_restart;   // frame_start seen while a request awaits its ack
   logic        r_wr_req;
   logic [23:0] r_wr_addr;
   logic        r_frame_written;
   logic [1:0]  r_latest_buf;
   logic        r_latest_valid;

   // Read side state
   logic [1:0]  r_rd_state;
   logic [1:0]  r_rd_buf;
   logic [23:0] r_rd_idx;
   logic        r_rd_req;
   logic [23:0] r_rd_addr;
   logic [10:0] r_inflight;
   logic        r_rd_busy;
   logic        r_rd_done;
   logic        r_rd_none;

   logic [1:0]  w_free_buf;
   logic        w_buf0_ok;
   logic        w_buf1_ok;
   logic        w_rd_accept;
   logic [10:0] w_inflight_nxt;

   function automatic logic [23:0] f_addr(input logic [1:0] bsel, input logic [23:0] idx);
      logic [23:0] base;
      case (bsel)
         2'd1:    base = BUF_BASE + BUF_STRIDE;
         2'd2:    base = BUF_BASE + (BUF_STRIDE << 1);
         default: base = BUF_BASE;
      endcase
      return base + (idx * BW24);
   endfunction

   // Lowest buffer not holding the latest complete frame and not being read.
   assign w_buf0_ok = !(r_latest_valid && (r_latest_buf == 2'd0)) &&
                      !(r_rd_busy && (r_rd_buf == 2'd0));
   assign w_buf1_ok = !(r_latest_valid && (r_latest_buf == 2'd1)) &&
                      !(r_rd_busy && (r_rd_buf == 2'd1));

   always_comb begin
      w_free_buf = 2'd2;
      if (w_buf1_ok) w_free_buf = 2'd1;
      if (w_buf0_ok) w_free_buf = 2'd0;
   end

   // ------------------------------------------------------------------ write
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_state      <= W_CALIB;
         r_wr_buf        <= 2'd0;
         r_wr_idx        <= 24'd0;
         r_wr_restart    <= 1'b0;
         r_wr_req        <= 1'b0;
         r_wr_addr       <= 24'd0;
         r_frame_written <= 1'b0;
         r_latest_buf    <= 2'd0;
         r_latest_valid  <= 1'b0;
      end else begin
         r_frame_written <= 1'b0;
         if (!i_calib_done) begin
            r_wr_state     <= W_CALIB;
            r_wr_req       <= 1'b0;
            r_wr_restart   <= 1'b0;
            r_latest_valid <= 1'b0;
         end else begin
            case (r_wr_state)
               W_CALIB: r_wr_state <= W_IDLE;
               W_IDLE: begin
                  if (i_frame_start) begin
                     r_wr_buf   <= w_free_buf;
                     r_wr_idx   <= 24'd0;
                     r_wr_state <= W_CHECK;
                  end
               end
               W_CHECK: begin
                  if (i_frame_start) begin
                     r_wr_idx <= 24'd0;
                  end else if ({1'b0, i_wfifo_count} >= BW11) begin
                     r_wr_req   <= 1'b1;
                     r_wr_addr  <= f_addr(r_wr_buf, r_wr_idx);
                     r_wr_state <= W_REQ;
                  end
               end
               W_REQ: begin
                  // The request stays up until acked; a restart is applied afterwards.
                  if (arb.wr_ack) begin
                     r_wr_req     <= 1'b0;
                     r_wr_idx     <= (r_wr_restart || i_frame_start) ? 24'd0 : r_wr_idx + 24'd1;
                     r_wr_restart <= 1'b0;
                     r_wr_state   <= W_RELEASE;
                  end else if (i_frame_start) begin
                     r_wr_restart <= 1'b1;
                  end
               end
               W_RELEASE: begin
                  if (i_frame_start) begin
                     r_wr_idx <= 24'd0;
                     if (!arb.wr_ack) r_wr_state <= W_CHECK;
                  end else if (!arb.wr_ack) begin
                     if (r_wr_idx == FRAME_BURSTS) begin
                        r_latest_buf    <= r_wr_buf;
                        r_latest_valid  <= 1'b1;
                        r_frame_written <= 1'b1;
                        r_wr_state      <= W_IDLE;
                     end else begin
                        r_wr_state <= W_CHECK;
                     end
                  end
               end
               default: r_wr_state <= W_CALIB;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------- read
   assign w_rd_accept = (r_rd_state == R_REQ) && arb.rd_ack;

   always_comb begin
      w_inflight_nxt = r_inflight;
      if (w_rd_accept) w_inflight_nxt = w_inflight_nxt + BW11;
      // Never wrap below zero on a stray data strobe.
      if (i_rdata_valid && (w_inflight_nxt != 11'd0)) w_inflight_nxt = w_inflight_nxt - 11'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_state <= R_IDLE;
         r_rd_buf   <= 2'd0;
         r_rd_idx   <= 24'd0;
         r_rd_req   <= 1'b0;
         r_rd_addr  <= 24'd0;
         r_inflight <= 11'd0;
         r_rd_busy  <= 1'b0;
         r_rd_done  <= 1'b0;
         r_rd_none  <= 1'b0;
      end else begin
         r_rd_done <= 1'b0;
         r_rd_none <= 1'b0;
         if (!i_calib_done) begin
            r_rd_state <= R_IDLE;
            r_rd_req   <= 1'b0;
            r_rd_busy  <= 1'b0;
            r_inflight <= 11'd0;
         end else begin
            r_inflight <= w_inflight_nxt;
            case (r_rd_state)
               R_IDLE: begin
                  if (i_rd_frame_req) begin
                     if (r_latest_valid) begin
                        r_rd_buf   <= r_latest_buf;
                        r_rd_busy  <= 1'b1;
                        r_rd_idx   <= 24'd0;
                        r_rd_state <= R_CHECK;
                     end else begin
                        r_rd_none <= 1'b1;
                     end
                  end
               end
               R_CHECK: begin
                  // Only request when the FIFO can absorb every word already owed.
                  if ({2'b00, i_rfifo_space} >= ({1'b0, r_inflight} + BW12)) begin
                     r_rd_req   <= 1'b1;
                     r_rd_addr  <= f_addr(r_rd_buf, r_rd_idx);
                     r_rd_state <= R_REQ;
                  end
               end
               R_REQ: begin
                  if (arb.rd_ack) begin
                     r_rd_req   <= 1'b0;
                     r_rd_idx   <= r_rd_idx + 24'd1;
                     r_rd_state <= R_RELEASE;
                  end
               end
               R_RELEASE: begin
                  if (!arb.rd_ack) begin
                     if (r_rd_idx == FRAME_BURSTS) begin
                        if (r_inflight == 11'd0) begin
                           r_rd_done  <= 1'b1;
                           r_rd_busy  <= 1'b0;
                           r_rd_state <= R_IDLE;
                        end
                     end else begin
                        r_rd_state <= R_CHECK;
                     end
                  end
               end
               default: r_rd_state <= R_IDLE;
            endcase
         end
      end
   end

   // -------------------------------------------------------------- statistics
`ifdef FBSEQ_STATS_EN
   logic [15:0] r_frames_written_cnt;
   logic [15:0] r_frames_dropped_cnt;
   logic        w_wr_active;
   logic        w_drop_evt;

   assign w_wr_active = (r_wr_state == W_CHECK) || (r_wr_state == W_REQ) ||
                        (r_wr_state == W_RELEASE);
   // New frame or lost calibration while a frame is in progress aborts it.
   assign w_drop_evt  = w_wr_active && (i_frame_start || !i_calib_done);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_frames_written_cnt <= 16'd0;
         r_frames_dropped_cnt <= 16'd0;
      end else begin
         if (r_frame_written && (r_frames_written_cnt != 16'hFFFF))
            r_frames_written_cnt <= r_frames_written_cnt + 16'd1;
         if (w_drop_evt && (r_frames_dropped_cnt != 16'hFFFF))
            r_frames_dropped_cnt <= r_frames_dropped_cnt + 16'd1;
      end
   end

   assign o_frames_written_cnt = r_frames_written_cnt;
   assign o_frames_dropped_cnt = r_frames_dropped_cnt;
`else
   assign o_frames_written_cnt = 16'd0;
   assign o_frames_dropped_cnt = 16'd0;
`endif

   assign o_rd_frame_busy = r_rd_busy;
   assign o_rd_frame_done = r_rd_done;
   assign o_rd_frame_none = r_rd_none;
   assign o_frame_written = r_frame_written;
   assign arb.wr_req      = r_wr_req;
   assign arb.wr_addr     = r_wr_addr;
   assign arb.rd_req      = r_rd_req;
   assign arb.rd_addr     = r_rd_addr;

endmodule
